reg_bus_arb: RTL and testbench
==============================

// Module: reg_bus_arb
// PURPOSE
//  Round-robin arbiter and sequencer sharing one register-bus target (regs block: addr/rd_wr/req/write_val -> read_val/ack)
//  between NUM_REQ_P software/hardware requesters. Serialises transactions: one outstanding access at a time.
//  Returns read data, completion pulse and error/timeout status to the requester that was granted.
// PARAMETERS
//  NUM_REQ_P    2   number of requesters (2..8)
//  ADDR_SIZE_P  4   register address width, matches regs target
//  TIMEOUT_P    15  cycles in WAIT_ACK before abort (only with REG_ARB_TIMEOUT_EN); 4-bit counter sized $clog2(TIMEOUT_P+1)
// PORTS
//  clk         in   1                      clock
//  reset       in   1                      async reset, active-high
//  rq_req      in   NUM_REQ_P              per-requester request level; hold until rq_done
//  rq_rd_wr    in   NUM_REQ_P              per-requester 1=read 0=write
//  rq_addr     in   NUM_REQ_P*ADDR_SIZE_P  flattened, requester i at [i*ADDR_SIZE_P +: ADDR_SIZE_P]
//  rq_wdata    in   NUM_REQ_P*32           flattened write data, requester i at [i*32 +: 32]
//  rq_done     out  NUM_REQ_P              one-hot 1-cycle completion pulse
//  rq_err      out  1                      valid with rq_done: 1 = timeout abort
//  rq_rdata    out  32                     valid with rq_done on reads; 0 on writes/aborts
//  addr        out  ADDR_SIZE_P            to regs target
//  rd_wr       out  1                      to regs target
//  req         out  1                      to regs target, 1-cycle pulse
//  write_val   out  32                     to regs target
//  read_val    in   32                     from regs target
//  ack         in   1                      from regs target
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, rr_ptr=0, all outputs 0 (addr, rd_wr, req, write_val, rq_done, rq_err, rq_rdata).
//  FSM IDLE -> ISSUE -> WAIT_ACK -> RESP -> IDLE. All outputs registered.
//  IDLE: if any rq_req, grant first set bit searching from rr_ptr upward with wrap; latch gnt idx, addr, rd_wr,
//   wdata into output regs; go ISSUE. No request: stay, req=0.
//  ISSUE: req=1 for exactly this cycle; addr/rd_wr/write_val held stable from ISSUE through WAIT_ACK (target
//   samples addr one cycle late). Go WAIT_ACK.
//  WAIT_ACK: on ack=1 capture read_val (reads) else 0 -> rq_rdata, rq_err=0, go RESP. ack while IDLE/ISSUE/RESP ignored.
//  RESP: rq_done[gnt]=1 one cycle; rr_ptr = gnt+1 (wrap to 0 at NUM_REQ_P); go IDLE.
//  Latency: rq_req high in IDLE -> req pulse 2 cycles later; ack at cycle N -> rq_done at N+1.
//   Min transaction = 4 cycles; back-to-back from different requesters, no bubble beyond RESP->IDLE.
//  Fairness: granted requester is lowest priority next arbitration; requester dropping rq_req mid-transaction
//   does not abort it (done still pulses). New rq_req samples only in IDLE.
//  rq_done/rq_err/rq_rdata return to 0 the cycle after RESP. addr/rd_wr/write_val retain last value in IDLE.
//  Reset mid-transaction: FSM to IDLE, pending transaction dropped, no rq_done.
// CONFIGURATION
//  REG_ARB_TIMEOUT_EN defined: counter cleared entering WAIT_ACK, increments each WAIT_ACK cycle without ack;
//   reaching TIMEOUT_P -> RESP with rq_err=1, rq_rdata=0. ack on the same cycle as the limit wins (rq_err=0).
//  Not defined: no counter; WAIT_ACK waits indefinitely for ack; rq_err tied 0.
// TESTING
//  T1 reset: assert reset mid-WAIT_ACK -> all outputs 0 same cycle, no rq_done after release, next grant to req 0.
//  T2 write: rq_req[0], addr=1, rd_wr=0, wdata=0x5A5A_0001 -> req pulse 2 cycles later with addr=1/write_val
//   held; ack after 1 cycle -> rq_done=2'b01, rq_err=0, rq_rdata=0.
//  T3 read: rq_req[1], addr=0, rd_wr=1; target returns read_val=0x0000_0003 with ack -> next cycle rq_done=2'b10,
//   rq_rdata=0x3.
//  T4 round robin: rq_req=2'b11 held for 4 transactions -> grant order 0,1,0,1; exactly one req pulse per done.
//  T5 timeout (REG_ARB_TIMEOUT_EN, TIMEOUT_P=15): never ack -> rq_done after 15 WAIT_ACK cycles, rq_err=1,
//   rq_rdata=0; ack on cycle 15 -> rq_err=0. Without macro: no rq_done after 100 cycles.
//  T6 spurious ack while IDLE and during ISSUE -> ignored, no rq_done, FSM unchanged.

Source files
------------

// File: rtl/reg_bus_arb.sv
// reg_bus_arb: round-robin arbiter that serialises NUM_REQ_P requesters onto one register-bus target.
// Defining REG_ARB_TIMEOUT_EN enables a WAIT_ACK timeout that aborts with rq_err=1 after TIMEOUT_P cycles.
`default_nettype none

module reg_bus_arb #(
  parameter int NUM_REQ_P   = 2,
  parameter int ADDR_SIZE_P = 4,
  parameter int TIMEOUT_P   = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ_P-1:0]             rq_req,
  input  logic [NUM_REQ_P-1:0]             rq_rd_wr,
  input  logic [NUM_REQ_P*ADDR_SIZE_P-1:0] rq_addr,
  input  logic [NUM_REQ_P*32-1:0]          rq_wdata,
  output logic [NUM_REQ_P-1:0]             rq_done,
  output logic                             rq_err,
  output logic [31:0]                      rq_rdata,
  output logic [ADDR_SIZE_P-1:0]           addr,
  output logic                             rd_wr,
  output logic                             req,
  output logic [31:0]                      write_val,
  input  logic [31:0]                      read_val,
  input  logic                             ack
);

  localparam int IDX_W = $clog2(NUM_REQ_P);

  if (NUM_REQ_P < 2 || NUM_REQ_P > 8 || TIMEOUT_P < 1) begin : g_bad_params
    $error("reg_bus_arb: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gnt;
  logic [IDX_W-1:0]     gnt_inc;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic [NUM_REQ_P-1:0] gnt_onehot;
  int                   idx;

`ifdef REG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_P + 1);
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_P - 1));
`endif

  // Scan downward so the last hit written is the first set bit at or after rr_ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int i = NUM_REQ_P - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ_P) idx = idx - NUM_REQ_P;
      if (rq_req[idx[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_onehot      = '0;
    gnt_onehot[gnt] = 1'b1;
    gnt_inc         = (int'(gnt) == NUM_REQ_P - 1) ? '0 : gnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pick_vld) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_ACK;
      WAIT_ACK: begin
`ifdef REG_ARB_TIMEOUT_EN
        if (ack || timeout_hit) state_nxt = RESP;
`else
        if (ack) state_nxt = RESP;
`endif
      end
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      addr      <= '0;
      rd_wr     <= 1'b0;
      req       <= 1'b0;
      write_val <= '0;
      rq_done   <= '0;
      rq_err    <= 1'b0;
      rq_rdata  <= '0;
`ifdef REG_ARB_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      req      <= 1'b0;
      rq_done  <= '0;
      rq_err   <= 1'b0;
      rq_rdata <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt       <= pick_idx;
            addr      <= rq_addr[int'(pick_idx)*ADDR_SIZE_P +: ADDR_SIZE_P];
            rd_wr     <= rq_rd_wr[pick_idx];
            write_val <= rq_wdata[int'(pick_idx)*32 +: 32];
          end
        end
        ISSUE: begin
          req <= 1'b1;
`ifdef REG_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        WAIT_ACK: begin
          // ack takes precedence over a timeout landing on the same cycle
          if (ack) begin
            rq_done  <= gnt_onehot;
            rq_rdata <= rd_wr ? read_val : 32'h0;
          end
`ifdef REG_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            rq_done <= gnt_onehot;
            rq_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: rr_ptr <= gnt_inc;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_arb.sv
// tb_reg_bus_arb: directed stimulus for reg_bus_arb with a queue-based scoreboard; a monitor pops expected
// bus requests and responses whenever the DUT pulses req or rq_done.
`default_nettype none

module tb_reg_bus_arb;

  localparam int N  = 2;
  localparam int AW = 4;

  logic            clk      = 1'b0;
  logic            reset    = 1'b1;
  logic [N-1:0]    rq_req   = '0;
  logic [N-1:0]    rq_rd_wr = '0;
  logic [N*AW-1:0] rq_addr  = '0;
  logic [N*32-1:0] rq_wdata = '0;
  logic [N-1:0]    rq_done;
  logic            rq_err;
  logic [31:0]     rq_rdata;
  logic [AW-1:0]   addr;
  logic            rd_wr;
  logic            req;
  logic [31:0]     write_val;
  logic [31:0]     read_val;
  logic            ack;

  logic        tgt_ack   = 1'b0;
  logic        spur_ack  = 1'b0;
  logic        tgt_en    = 1'b1;
  logic [31:0] tgt_rval  = '0;
  logic [31:0] tgt_rdata = '0;
  int          tgt_delay = 1;

  assign ack      = tgt_ack | spur_ack;
  assign read_val = tgt_rval;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int req_cnt   = 0;
  int done_cnt  = 0;
  int req_cyc   = 0;
  int start_cyc = 0;
  int base_done = 0;
  int base_req  = 0;
  int done_times[$];
  logic [36:0] exp_bus[$];   // {addr, rd_wr, write_val}
  logic [34:0] exp_resp[$];  // {rq_done, rq_err, rq_rdata}

  reg_bus_arb #(
    .NUM_REQ_P  (N),
    .ADDR_SIZE_P(AW),
    .TIMEOUT_P  (15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rq_req   (rq_req),
    .rq_rd_wr (rq_rd_wr),
    .rq_addr  (rq_addr),
    .rq_wdata (rq_wdata),
    .rq_done  (rq_done),
    .rq_err   (rq_err),
    .rq_rdata (rq_rdata),
    .addr     (addr),
    .rd_wr    (rd_wr),
    .req      (req),
    .write_val(write_val),
    .read_val (read_val),
    .ack      (ack)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic bad(input string nm, input string msg);
    total_cnt++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // Register target: acks tgt_delay cycles after the cycle it sees req.
  initial forever begin
    @(negedge clk);
    if (req === 1'b1 && tgt_en) begin
      for (int k = 0; k < tgt_delay; k++) @(posedge clk);
      #1;
      tgt_ack  = 1'b1;
      tgt_rval = tgt_rdata;
      @(posedge clk);
      #1;
      tgt_ack  = 1'b0;
      tgt_rval = '0;
    end
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (req === 1'b1) begin
      req_cnt++;
      req_cyc = cyc;
      if (exp_bus.size() == 0) bad("bus_unexpected", $sformatf("actual req pulse addr=%0h, required none", addr));
      else chk("bus_fields", {addr, rd_wr, write_val}, exp_bus.pop_front());
    end
    if (rq_done !== '0) begin
      done_cnt++;
      done_times.push_back(cyc);
      if (exp_resp.size() == 0) bad("done_unexpected", $sformatf("actual rq_done=%b, required none", rq_done));
      else chk("resp", {rq_done, rq_err, rq_rdata}, exp_resp.pop_front());
    end
  end

  // kind: 0 = normal completion, 1 = timeout abort, 2 = no response expected
  task automatic txn_start(input int idx, input logic rd, input logic [3:0] a, input logic [31:0] wd,
                           input logic [31:0] rv, input logic en, input int dly, input int kind);
    logic [N-1:0] d;
    d      = '0;
    d[idx] = 1'b1;
    tgt_en    = en;
    tgt_delay = dly;
    tgt_rdata = rv;
    exp_bus.push_back({a, rd, wd});
    if (kind == 0) exp_resp.push_back({d, 1'b0, (rd ? rv : 32'h0)});
    else if (kind == 1) exp_resp.push_back({d, 1'b1, 32'h0});
    rq_rd_wr[idx]          = rd;
    rq_addr[idx*AW +: AW]  = a;
    rq_wdata[idx*32 +: 32] = wd;
    rq_req[idx]            = 1'b1;
    start_cyc              = cyc;
  endtask

  task automatic wait_done_cnt(input int target, input string nm);
    int k;
    k = 0;
    while (done_cnt < target && k < 80) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (done_cnt < target) bad(nm, $sformatf("actual %0d completions, required %0d within budget", done_cnt, target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    chk("reset_ctl", {rq_done, rq_err, addr, rd_wr, req}, '0);
    chk("reset_data", {rq_rdata, write_val}, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write from requester 0; target returns junk read_val that must not appear
    txn_start(0, 1'b0, 4'h1, 32'h5A5A_0001, 32'hFFFF_FFFF, 1'b1, 1, 0);
    wait_done_cnt(1, "t2_done");
    rq_req = '0;
    chk("t2_req_latency", req_cyc - start_cyc, 2);
    chk("t2_done_latency", done_times[$] - req_cyc, 2);
    chk("t2_bus_hold_idle", {addr, write_val}, {4'h1, 32'h5A5A_0001});

    // Read from requester 1
    txn_start(1, 1'b1, 4'h0, 32'h0, 32'h0000_0003, 1'b1, 1, 0);
    wait_done_cnt(2, "t3_done");
    rq_req = '0;

    // Both requesting: grants alternate 0,1,0,1 with no extra bubbles
    tgt_en    = 1'b1;
    tgt_delay = 0;
    tgt_rdata = 32'h1234_5678;
    rq_rd_wr  = 2'b10;
    rq_addr   = {4'h3, 4'h2};
    rq_wdata  = {32'h0000_00B1, 32'h0000_00A0};
    for (int t = 0; t < 2; t++) begin
      exp_bus.push_back({4'h2, 1'b0, 32'h0000_00A0});
      exp_bus.push_back({4'h3, 1'b1, 32'h0000_00B1});
      exp_resp.push_back({2'b01, 1'b0, 32'h0});
      exp_resp.push_back({2'b10, 1'b0, 32'h1234_5678});
    end
    base_req = req_cnt;
    rq_req   = 2'b11;
    wait_done_cnt(6, "t4_done");
    rq_req = '0;
    chk("t4_req_per_done", req_cnt - base_req, 4);
    chk("t4_b2b_spacing", done_times[$] - done_times[done_times.size()-2], 4);

    // Spurious ack while idle
    base_done = done_cnt;
    base_req  = req_cnt;
    spur_ack  = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_no_done", done_cnt, base_done);
    chk("t6_idle_no_req", req_cnt, base_req);

    // Spurious ack during ISSUE must not complete the transaction early
    txn_start(0, 1'b0, 4'h5, 32'h0000_0066, 32'h0000_0077, 1'b1, 3, 0);
    @(posedge clk);
    #1 spur_ack = 1'b1;
    @(posedge clk);
    #1 spur_ack = 1'b0;
    wait_done_cnt(base_done + 1, "t6_done");
    rq_req = '0;
    chk("t6_issue_ack_ignored", done_times[$] - req_cyc, 4);

`ifdef REG_ARB_TIMEOUT_EN
    txn_start(1, 1'b1, 4'h7, 32'h0, 32'hDEAD_0000, 1'b0, 0, 1);
    wait_done_cnt(base_done + 2, "t5_timeout_done");
    rq_req = '0;
    chk("t5_timeout_latency", done_times[$] - req_cyc, 15);
    txn_start(0, 1'b1, 4'h8, 32'h0, 32'h0000_BEEF, 1'b1, 14, 0);
    wait_done_cnt(base_done + 3, "t5_limit_done");
    rq_req = '0;
    chk("t5_ack_at_limit_latency", done_times[$] - req_cyc, 15);
    base_done = done_cnt;
    base_req  = req_cnt;
    txn_start(1, 1'b1, 4'h7, 32'h0BAD_F00D, 32'h0, 1'b0, 0, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_req_issued", req_cnt, base_req + 1);
`else
    base_done = done_cnt;
    base_req  = req_cnt;
    txn_start(1, 1'b1, 4'h7, 32'h0BAD_F00D, 32'h0, 1'b0, 0, 2);
    repeat (100) @(posedge clk);
    #1;
    chk("t5_no_timeout", done_cnt, base_done);
    chk("t5_req_issued", req_cnt, base_req + 1);
`endif

    // Asynchronous reset while waiting for ack
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t1_ctl_zero", {rq_done, rq_err, addr, rd_wr, req}, '0);
    chk("t1_data_zero", {rq_rdata, write_val}, '0);
    rq_req = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    base_done = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("t1_no_done_after_reset", done_cnt, base_done);

    // Pointer back at 0: requester 0 wins over requester 1
    rq_rd_wr[1]     = 1'b1;
    rq_addr[AW +: AW] = 4'hC;
    rq_req[1]       = 1'b1;
    txn_start(0, 1'b0, 4'h9, 32'h0000_0099, 32'h0, 1'b1, 1, 0);
    wait_done_cnt(base_done + 1, "t1_regrant_done");
    rq_req = '0;

    repeat (5) @(posedge clk);
    #1;
    chk("queues_drained", {32'(exp_bus.size()), 32'(exp_resp.size())}, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
